// File: rtl/fp_mul_pipe_pkg.sv
// Shared definitions for the pipelined floating-point multiplier:
// error codes, operand classes and format helper functions.
package fp_pkg;

   localparam logic [1:0] FP_ERR_NONE = 2'b00;
   localparam logic [1:0] FP_ERR_OVF  = 2'b01;
   localparam logic [1:0] FP_ERR_UNF  = 2'b10;
   localparam logic [1:0] FP_ERR_NAN  = 2'b11;

   typedef enum logic [1:0] {
      FP_CLS_NORMAL = 2'd0,
      FP_CLS_ZERO   = 2'd1,
      FP_CLS_INF    = 2'd2,
      FP_CLS_NAN    = 2'd3
   } fp_class_e;

   // Exponent bias for an IEEE-style format with exp_width exponent bits.
   function automatic int fp_bias(input int exp_width);
      return (1 << (exp_width - 1)) - 1;
   endfunction

   // Total operand width: sign + exponent + stored fraction.
   function automatic int fp_data_width(input int exp_width, input int frac_width);
      return 1 + exp_width + frac_width;
   endfunction

endpackage

// File: rtl/fp_mul_pipe_if.sv
// Operand/result handshake bundle for fp_mul_pipe.
// master = producer/consumer side, slave = the multiplier.
interface fp_mul_pipe_if #(
   parameter int DATA_WIDTH  = 16,
   parameter int ERROR_WIDTH = 2
);
   logic                   in_valid;
   logic                   in_ready;
   logic [DATA_WIDTH-1:0]  in_a;
   logic [DATA_WIDTH-1:0]  in_b;
   logic                   out_valid;
   logic                   out_ready;
   logic [DATA_WIDTH-1:0]  out_data;
   logic [ERROR_WIDTH-1:0] out_error;

   modport master (
      output in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_data, out_error
   );

   modport slave (
      input  in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid, out_data, out_error
   );
endinterface

// File: rtl/fp_mul_pipe_classify.sv
// Operand splitter/classifier: breaks an operand into sign, exponent and
// hidden-bit mantissa and tags it normal/zero/inf/nan. Subnormals count as zero.
module fp_classify
   import fp_pkg::*;
#(
   parameter int EXP_WIDTH  = 8,
   parameter int FRAC_WIDTH = 7,
   parameter int DATA_WIDTH = fp_data_width(EXP_WIDTH, FRAC_WIDTH)
) (
   input  logic [DATA_WIDTH-1:0] op,
   output logic                  sign,
   output logic [EXP_WIDTH-1:0]  exponent,
   output logic [FRAC_WIDTH:0]   mant,
   output fp_class_e             cls
);
   logic [FRAC_WIDTH-1:0] frac;

   assign sign     = op[DATA_WIDTH-1];
   assign exponent = op[DATA_WIDTH-2 -: EXP_WIDTH];
   assign frac     = op[FRAC_WIDTH-1:0];
   assign mant     = {1'b1, frac};

   // class decode from the exponent/fraction fields
   always_comb begin
      cls = FP_CLS_NORMAL;
      if (&exponent)
         cls = (|frac) ? FP_CLS_NAN : FP_CLS_INF;
      else if (exponent == '0)
         cls = FP_CLS_ZERO;
   end
endmodule

// File: rtl/fp_mul_pipe.sv
// 3-stage pipelined floating-point multiplier (classify / multiply /
// normalise-round-pack) with valid/ready flow control and a 2-bit error code.
// Optional feature: define FP_MUL_RNE_EN for round-to-nearest-even; without
// it the fraction is truncated.
module fp_mul_pipe
   import fp_pkg::*;
#(
   parameter int EXP_WIDTH   = 8,
   parameter int FRAC_WIDTH  = 7,
   parameter int DATA_WIDTH  = fp_data_width(EXP_WIDTH, FRAC_WIDTH),
   parameter int ERROR_WIDTH = 2
) (
   input logic          clk,
   input logic          rst_n,
   fp_mul_pipe_if.slave bus
);
   localparam int STAGES = 3;
   localparam int MW     = FRAC_WIDTH + 1;
   localparam int PW     = 2 * MW;
   localparam int E2W    = EXP_WIDTH + 2;
   localparam logic [E2W-1:0]        BIAS_E  = E2W'(fp_bias(EXP_WIDTH));
   localparam logic signed [E2W-1:0] EXP_MAX = E2W'((1 << EXP_WIDTH) - 1);
   localparam logic signed [E2W-1:0] E_ZERO  = '0;

   // valid shift register: bit 0 is the incoming valid, bit STAGES is out_valid
   logic [STAGES:1] vld_q;
   logic [STAGES:0] vld_pipe;
   logic            stall;

   assign vld_pipe     = {vld_q, bus.in_valid};
   assign stall        = vld_q[STAGES] & ~bus.out_ready;
   assign bus.in_ready = ~stall;
   assign bus.out_valid = vld_q[STAGES];

   // advance valids whenever the output is not blocked
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         vld_q <= '0;
      else if (!stall)
         vld_q <= vld_pipe[STAGES-1:0];
   end

   // ---------------- stage 1: classify ----------------
   logic                 sa, sb;
   logic [EXP_WIDTH-1:0] ea, eb;
   logic [MW-1:0]        ma, mb;
   fp_class_e            cls_a, cls_b;

   fp_classify #(.EXP_WIDTH(EXP_WIDTH), .FRAC_WIDTH(FRAC_WIDTH), .DATA_WIDTH(DATA_WIDTH))
      u_cls_a (.op(bus.in_a), .sign(sa), .exponent(ea), .mant(ma), .cls(cls_a));
   fp_classify #(.EXP_WIDTH(EXP_WIDTH), .FRAC_WIDTH(FRAC_WIDTH), .DATA_WIDTH(DATA_WIDTH))
      u_cls_b (.op(bus.in_b), .sign(sb), .exponent(eb), .mant(mb), .cls(cls_b));

   logic                  s1_sign, s1_nan, s1_inf, s1_zero;
   logic signed [E2W-1:0] s1_e;
   logic [MW-1:0]         s1_ma, s1_mb;

   // capture special flags, product sign and biased exponent sum
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_sign <= 1'b0;
         s1_nan  <= 1'b0;
         s1_inf  <= 1'b0;
         s1_zero <= 1'b0;
         s1_e    <= '0;
         s1_ma   <= '0;
         s1_mb   <= '0;
      end else if (!stall && vld_pipe[0]) begin
         s1_sign <= sa ^ sb;
         // inf x 0 is invalid, same as a NaN operand
         s1_nan  <= (cls_a == FP_CLS_NAN) || (cls_b == FP_CLS_NAN) ||
                    (cls_a == FP_CLS_INF && cls_b == FP_CLS_ZERO) ||
                    (cls_a == FP_CLS_ZERO && cls_b == FP_CLS_INF);
         s1_inf  <= (cls_a == FP_CLS_INF) || (cls_b == FP_CLS_INF);
         s1_zero <= (cls_a == FP_CLS_ZERO) || (cls_b == FP_CLS_ZERO);
         s1_e    <= {2'b00, ea} + {2'b00, eb} - BIAS_E;
         s1_ma   <= ma;
         s1_mb   <= mb;
      end
   end

   // ---------------- stage 2: multiply ----------------
   logic                  s2_sign, s2_nan, s2_inf, s2_zero;
   logic signed [E2W-1:0] s2_e;
   logic [PW-1:0]         s2_prod;

   // full-width mantissa product, specials and exponent carried alongside
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_sign <= 1'b0;
         s2_nan  <= 1'b0;
         s2_inf  <= 1'b0;
         s2_zero <= 1'b0;
         s2_e    <= '0;
         s2_prod <= '0;
      end else if (!stall && vld_pipe[1]) begin
         s2_sign <= s1_sign;
         s2_nan  <= s1_nan;
         s2_inf  <= s1_inf;
         s2_zero <= s1_zero;
         s2_e    <= s1_e;
         s2_prod <= PW'(s1_ma) * PW'(s1_mb);
      end
   end

   // ---------------- stage 3: normalise / round / pack ----------------
   logic                  msb, guard, sticky, carry;
   logic [PW-1:0]         norm;
   logic [FRAC_WIDTH-1:0] frac, frac_r;
   logic signed [E2W-1:0] e_n, e_f;
   logic                  unused_norm;

   // product lies in [1,4): when >= 2 take one extra bit off and bump e
   assign msb    = s2_prod[PW-1];
   assign norm   = msb ? s2_prod : (s2_prod << 1);
   assign frac   = norm[PW-2 -: FRAC_WIDTH];
   assign guard  = norm[PW-2-FRAC_WIDTH];
   assign sticky = |norm[PW-3-FRAC_WIDTH:0];
   assign e_n    = s2_e + E2W'(msb);

`ifdef FP_MUL_RNE_EN
   logic inc;
   assign inc              = guard & (sticky | frac[0]);
   // carry-out means mantissa rolled over to 2.0: fraction wraps to 0
   assign {carry, frac_r}  = {1'b0, frac} + MW'(inc);
   assign unused_norm      = norm[PW-1];
`else
   assign carry       = 1'b0;
   assign frac_r      = frac;
   assign unused_norm = ^{norm[PW-1], guard, sticky};
`endif

   assign e_f = e_n + E2W'(carry);

   logic [DATA_WIDTH-1:0]  res;
   logic [ERROR_WIDTH-1:0] err;

   // result selection in priority order; range checks use the rounded exponent
   always_comb begin
      res = {s2_sign, e_f[EXP_WIDTH-1:0], frac_r};
      err = ERROR_WIDTH'(FP_ERR_NONE);
      if (s2_nan) begin
         res = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(FRAC_WIDTH-1){1'b0}}};
         err = ERROR_WIDTH'(FP_ERR_NAN);
      end else if (s2_inf) begin
         res = {s2_sign, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
      end else if (s2_zero) begin
         res = {s2_sign, {(EXP_WIDTH+FRAC_WIDTH){1'b0}}};
      end else if (e_f >= EXP_MAX) begin
         res = {s2_sign, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
         err = ERROR_WIDTH'(FP_ERR_OVF);
      end else if (e_f <= E_ZERO) begin
         res = {s2_sign, {(EXP_WIDTH+FRAC_WIDTH){1'b0}}};
         err = ERROR_WIDTH'(FP_ERR_UNF);
      end
   end

   logic [DATA_WIDTH-1:0]  data_q;
   logic [ERROR_WIDTH-1:0] err_q;

   // output register; held while the consumer stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         err_q  <= '0;
      end else if (!stall && vld_pipe[2]) begin
         data_q <= res;
         err_q  <= err;
      end
   end

   assign bus.out_data  = data_q;
   assign bus.out_error = err_q;
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed-vector bench for fp_mul_pipe: table of hand-computed products,
// a backpressured stream against an arithmetic reference, and mid-stream reset.
module tb_fp_mul_pipe;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   fp_mul_pipe_if #(.DATA_WIDTH(16), .ERROR_WIDTH(2)) bus ();

   fp_mul_pipe dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct {
      string       name;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] exp_d;
      logic [1:0]  exp_e;
   } vec_t;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Reference: integer mantissa product, remainder-based rounding.
   function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b);
      int ea, eb, fa, fb, e, sh;
      logic s;
      longint prod, q, r, half;
      logic [7:0]  e8;
      logic [6:0]  f7;
      ea = int'(a[14:7]); eb = int'(b[14:7]);
      fa = int'(a[6:0]);  fb = int'(b[6:0]);
      s  = a[15] ^ b[15];
      if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0) ||
          (ea == 255 && eb == 0) || (eb == 255 && ea == 0))
         return {2'b11, 16'h7FC0};
      if (ea == 255 || eb == 255)
         return {2'b00, s, 8'hFF, 7'h00};
      if (ea == 0 || eb == 0)
         return {2'b00, s, 15'h0000};
      prod = longint'(128 + fa) * longint'(128 + fb);
      e = ea + eb - 127;
      if (prod >= 32768) begin sh = 8; e++; end
      else sh = 7;
      q = prod >> sh;
      r = prod - (q << sh);
      half = longint'(1) << (sh - 1);
`ifdef FP_MUL_RNE_EN
      if (r > half || (r == half && (q % 2) == 1)) q++;
`else
      if (r > half) q = q + 0;
`endif
      if (q == 256) begin q = 128; e++; end
      if (e >= 255) return {2'b01, s, 8'hFF, 7'h00};
      if (e <= 0)   return {2'b10, s, 15'h0000};
      e8 = e[7:0];
      f7 = q[6:0];
      return {2'b00, s, e8, f7};
   endfunction

   localparam logic [15:0] RND_EXP =
`ifdef FP_MUL_RNE_EN
      16'h4012;
`else
      16'h4011;
`endif

   vec_t tbl [9];

   // issue one operand pair, wait for its result, check latency and value
   task automatic run_vec(input vec_t v);
      int lat;
      bit got;
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_a      = v.a;
      bus.in_b      = v.b;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      lat = 0; got = 1'b0;
      while (!got && lat < 10) begin
         @(negedge clk);
         lat++;
         if (bus.out_valid) got = 1'b1;
      end
      check({v.name, " latency"}, 32'(lat), 32'd3);
      check({v.name, " data"}, 32'(bus.out_data), 32'(v.exp_d));
      check({v.name, " error"}, 32'(bus.out_error), 32'(v.exp_e));
   endtask

   logic [15:0] va [10];
   logic [15:0] vb [10];
   logic [17:0] exp_q [$];

   initial begin
      int sent, rcvd, cyc;
      bit prev_stall, take_in, take_out, clean;
      logic [15:0] prev_data;
      logic [1:0]  prev_err;
      logic [17:0] e;

      tbl[0] = '{"basic",    16'h3FC0, 16'h4040, 16'h4090, 2'b00};
      tbl[1] = '{"round",    16'h3FC1, 16'h3FC1, RND_EXP,  2'b00};
      tbl[2] = '{"overflow", 16'h7F00, 16'h4000, 16'h7F80, 2'b01};
      tbl[3] = '{"underflow",16'h0080, 16'h3F00, 16'h0000, 2'b10};
      tbl[4] = '{"inf_x_0",  16'h7F80, 16'h0000, 16'h7FC0, 2'b11};
      tbl[5] = '{"neg_inf",  16'hFF80, 16'h4000, 16'hFF80, 2'b00};
      tbl[6] = '{"subnorm",  16'h0001, 16'h4000, 16'h0000, 2'b00};
      tbl[7] = '{"neg_norm", 16'hC000, 16'h4000, 16'hC080, 2'b00};
      tbl[8] = '{"nan_in",   16'h7FC1, 16'h3F80, 16'h7FC0, 2'b11};

      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.out_ready = 1'b0;

      // reset state
      repeat (2) @(negedge clk);
      check("rst out_valid", 32'(bus.out_valid), 32'd0);
      check("rst out_data",  32'(bus.out_data),  32'd0);
      check("rst out_error", 32'(bus.out_error), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst in_ready", 32'(bus.in_ready), 32'd1);

      // directed table
      for (int i = 0; i < 9; i++) run_vec(tbl[i]);

      // backpressured stream against the reference
      for (int i = 0; i < 10; i++) begin
         va[i] = {1'($urandom), 8'($urandom_range(100, 150)), 7'($urandom)};
         vb[i] = {1'($urandom), 8'($urandom_range(100, 150)), 7'($urandom)};
      end
      vb[9] = 16'($urandom);
      sent = 0; rcvd = 0; cyc = 0; prev_stall = 1'b0;
      prev_data = '0; prev_err = '0;
      while ((sent < 10 || rcvd < 10) && cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (prev_stall) begin
            check("stall hold valid", 32'(bus.out_valid), 32'd1);
            check("stall hold data", {14'd0, bus.out_error, bus.out_data},
                  {14'd0, prev_err, prev_data});
         end
         bus.out_ready = 1'($urandom_range(0, 1));
         if (sent < 10) begin
            bus.in_valid = 1'b1;
            bus.in_a     = va[sent];
            bus.in_b     = vb[sent];
         end else begin
            bus.in_valid = 1'b0;
         end
         #1;
         take_in  = bus.in_valid && bus.in_ready;
         take_out = bus.out_valid && bus.out_ready;
         if (take_out) begin
            if (exp_q.size() == 0) begin
               check("stream spurious result", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check($sformatf("stream result %0d", rcvd),
                     {14'd0, bus.out_error, bus.out_data}, {14'd0, e});
            end
            rcvd++;
         end
         if (take_in) begin
            exp_q.push_back(model(va[sent], vb[sent]));
            sent++;
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_data  = bus.out_data;
         prev_err   = bus.out_error;
      end
      check("stream received count", 32'(rcvd), 32'd10);
      check("stream leftover", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;

      // reset with three results in flight
      repeat (3) @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_a = tbl[0].a; bus.in_b = tbl[0].b;
      @(posedge clk);
      #1 bus.in_a = tbl[5].a; bus.in_b = tbl[5].b;
      @(posedge clk);
      #1 bus.in_a = tbl[7].a; bus.in_b = tbl[7].b;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      check("inflight out_valid before reset", 32'(bus.out_valid), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("reset out_valid immediate", 32'(bus.out_valid), 32'd0);
      check("reset out_data immediate", 32'(bus.out_data), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      clean = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if (bus.out_valid) clean = 1'b0;
      end
      check("no stale after reset", 32'(clean), 32'd1);
      run_vec(tbl[0]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fp_mul_pipe.md
# fp_mul_pipe

Pipelined, parametrised floating-point multiplier for the bfloat16 datapath: the clocked successor to the combinational multiplier, with any exponent/fraction split, valid/ready flow control, an optional round-to-nearest-even stage and the existing 2-bit error encoding. It sits between operand buffers and the accumulator, sustaining one product per cycle at a fixed 3-cycle latency.

## Interface
- EXP_WIDTH, 8, exponent bits
- FRAC_WIDTH, 7, stored fraction bits (hidden bit implicit)
- DATA_WIDTH, 1+EXP_WIDTH+FRAC_WIDTH, operand/result width
- ERROR_WIDTH, 2, error code width
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand pair present
- in_ready  output  1  pipeline accepts operands this cycle
- in_a, in_b  input  DATA_WIDTH  operands {sign, exp, frac}
- out_valid  output  1  result present
- out_ready  input  1  consumer takes result this cycle
- out_data  output  DATA_WIDTH  product
- out_error  output  ERROR_WIDTH  00 none, 01 overflow, 10 underflow, 11 NaN

## Operation
- Stage 1 (classify): per operand NaN (exp all-ones, frac≠0), inf (exp all-ones, frac=0), zero (exp=0; subnormals flushed to zero, no error); sign = a.sign^b.sign; signed exponent sum e = ea+eb−BIAS in EXP_WIDTH+2 bits, BIAS = 2^(EXP_WIDTH−1)−1.
- Stage 2 (multiply): (2·FRAC_WIDTH+2)-bit product {1,fa}×{1,fb}; special flags and e carried alongside.
- Stage 3 (normalise/round/pack): product MSB set → shift right 1, e+1; guard bit and sticky (OR of remaining lower bits) extracted; rounding per Configuration; mantissa carry-out on rounding → e+1, fraction 0.
- Result priority: NaN (any NaN input, inf×0) → {0, all-ones, 1 followed by zeros}, error 11; else inf input → {sign, all-ones, 0}, error 00; else zero input → {sign, 0, 0}, error 00; else e ≥ all-ones → {sign, all-ones, 0}, error 01; else e ≤ 0 → {sign, 0, 0}, error 10; else normal, error 00.
- Overflow/underflow are tested after rounding.

## Timing
- Reset: all stage valids 0, out_valid 0, out_data 0, out_error 0; in_ready 1 after reset release.
- stall = out_valid & ~out_ready; in_ready = ~stall (combinational).
- stall: every stage register holds; out_data/out_error stable.
- Transfer on in_valid & in_ready; result appears with out_valid exactly 3 cycles later with no stall; throughput 1/cycle.
- Bubbles travel as invalid stages; not collapsed.
- Reset asserted mid-stream discards all in-flight results; no partial output.
- Simultaneous accept and output transfer in same cycle always legal.

## Configuration
- FP_MUL_RNE_EN defined: round-to-nearest-even (increment if guard & (sticky | lsb)).
- Not defined: truncation (guard/sticky ignored), bit-identical to the combinational multiplier for normal results; rounding logic absent.

## Structure
- Package fp_pkg: error-code constants (FP_ERR_NONE/OVF/UNF/NAN), operand-class enum (normal, zero, inf, nan), bias/width helper functions.
- Sub-module fp_classify: one instance per operand in stage 1, DATA_WIDTH-parametrised, outputs the class enum.

## Test plan
- Basic: 0x3FC0 × 0x4040 (1.5×3.0) → 0x4090, error 00, out_valid 3 cycles after accept.
- Rounding: 0x3FC1 × 0x3FC1 → 0x4012 with FP_MUL_RNE_EN, 0x4011 without.
- Overflow: 0x7F00 × 0x4000 → 0x7F80, error 01; underflow: 0x0080 × 0x3F00 → 0x0000, error 10.
- Specials: 0x7F80 × 0x0000 → 0x7FC0, error 11; 0xFF80 × 0x4000 → 0xFF80, error 00; 0x0001 × 0x4000 → 0x0000, error 00.
- Backpressure: stream 10 random pairs back-to-back, out_ready toggled pseudo-randomly → every result matches scoreboard in order, none dropped/duplicated, out_data stable while stalled.
- Reset with 3 results in flight → out_valid 0 immediately, no stale results after release.
